space_invaders_game_ctrl: RTL and testbench
===========================================

SPACE_INVADERS_GAME_CTRL -- requirements
Module: space_invaders_game_ctrl

Interface
REQ-001 SHALL provide parameter INIT_LIVES, default 3, lives loaded at game start (range 1..3).
REQ-002 SHALL provide parameter PAUSE_FRAMES, default 60, number of frame_tick pulses per pause (range 1..255).
REQ-003 SHALL provide parameter MAX_LEVEL, default 15, saturation value of level (range 1..15).
REQ-004 SHALL have port clk_12MHz  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset; reset is asynchronous and active-low.
REQ-006 SHALL have port start  input  1  start button, level, already synchronous to clk_12MHz.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port player_hit  input  1  one-cycle pulse, player cannon destroyed.
REQ-009 SHALL have port wave_cleared  input  1  one-cycle pulse, last invader destroyed.
REQ-010 SHALL have port invaders_landed  input  1  one-cycle pulse, invader reached cannon row.
REQ-011 SHALL have port state  output  3  current state encoding (IDLE=0, INIT=1, PLAY=2, HIT_PAUSE=3, WAVE_PAUSE=4, OVER=5).
REQ-012 SHALL have port field_init  output  1  one-cycle pulse, re-initialise invader field, shields, cannon position.
REQ-013 SHALL have port play_enable  output  1  high while movement/shooting/invader stepping permitted.
REQ-014 SHALL have port lives  output  2  remaining lives.
REQ-015 SHALL have port level  output  4  current wave number, 0-based.
REQ-016 SHALL have port game_over  output  1  high while in OVER.

Function
REQ-017 All outputs SHALL be registered; play_enable = (state==PLAY), game_over = (state==OVER), both registered with state.
REQ-018 start_event SHALL be start high with registered start_q low; start_q SHALL reset to 1 so a button held through reset does not start a game.
REQ-019 IDLE: on start_event -> INIT next cycle, lives <= INIT_LIVES, level <= 0.
REQ-020 INIT: SHALL last exactly one cycle with field_init=1, then -> PLAY; field_init SHALL be 0 in every other state.
REQ-021 PLAY event priority when coincident: invaders_landed > player_hit > wave_cleared; only the highest is acted on, others dropped.
REQ-022 PLAY + invaders_landed -> OVER, lives <= 0.
REQ-023 PLAY + player_hit: lives <= lives-1; if lives was 1 -> OVER, else -> HIT_PAUSE.
REQ-024 PLAY + wave_cleared -> WAVE_PAUSE, level <= level+1 saturating at MAX_LEVEL.
REQ-025 Entering HIT_PAUSE or WAVE_PAUSE SHALL clear an 8-bit pause counter; counter increments on each frame_tick.
REQ-026 On the frame_tick that brings the counter to PAUSE_FRAMES: HIT_PAUSE -> PLAY (no field_init, invader field retained); WAVE_PAUSE -> INIT.
REQ-027 player_hit, wave_cleared, invaders_landed SHALL be ignored outside PLAY; frame_tick SHALL be ignored outside pause states.
REQ-028 OVER: lives, level held; on start_event -> INIT with lives <= INIT_LIVES, level <= 0.
REQ-029 start SHALL be ignored in INIT, PLAY and both pause states.
REQ-030 lives SHALL never underflow; level SHALL never exceed MAX_LEVEL.
REQ-031 Unused state encodings (6, 7) SHALL transition to IDLE next cycle.

Reset
REQ-032 While reset is low: state=IDLE, lives=0, level=0, field_init=0, play_enable=0, game_over=0, pause counter=0, start_q=1.
REQ-033 Reset asserted mid-game (any state) SHALL force the REQ-032 values immediately, without waiting for a clock edge.
REQ-034 After reset release, first action requires a start_event.

Verification (PAUSE_FRAMES=2, INIT_LIVES=3, MAX_LEVEL=15)
REQ-035 Release reset with start held high -> stays IDLE; drop then raise start -> field_init pulse one cycle later, then state=PLAY, lives=3, level=0, play_enable=1.
REQ-036 In PLAY pulse player_hit -> lives=2, state=HIT_PAUSE, play_enable=0; two frame_ticks -> PLAY, no field_init pulse.
REQ-037 Three player_hit pulses, each followed by pause completion -> final lives=0, state=OVER, game_over=1; start_event -> INIT, lives=3, level=0.
REQ-038 player_hit and wave_cleared in same PLAY cycle -> lives decremented, level unchanged, state=HIT_PAUSE; invaders_landed with player_hit -> OVER, lives=0.
REQ-039 16 wave_cleared cycles each with 2 frame_ticks -> level saturates at 15, field_init pulses once per wave plus initial.
REQ-040 Assert reset during WAVE_PAUSE with counter=1 -> all outputs at REQ-032 values before next clock edge; player_hit pulses in IDLE ignored.

Source files
------------

// File: rtl/space_invaders_game_ctrl.sv
// Game-flow controller for a Space Invaders style game: sequences start, play,
// per-hit and per-wave pauses and game over, tracking lives and wave number.
module space_invaders_game_ctrl #(
    parameter int INIT_LIVES   = 3,
    parameter int PAUSE_FRAMES = 60,
    parameter int MAX_LEVEL    = 15
) (
    input  logic       clk_12MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       player_hit,
    input  logic       wave_cleared,
    input  logic       invaders_landed,
    output logic [2:0] state,
    output logic       field_init,
    output logic       play_enable,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       game_over
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_INIT       = 3'd1;
    localparam logic [2:0] ST_PLAY       = 3'd2;
    localparam logic [2:0] ST_HIT_PAUSE  = 3'd3;
    localparam logic [2:0] ST_WAVE_PAUSE = 3'd4;
    localparam logic [2:0] ST_OVER       = 3'd5;

    localparam logic [1:0] LIVES_INIT = 2'(INIT_LIVES);
    localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [8:0] PAUSE_LAST = 9'(PAUSE_FRAMES);

    logic [2:0] state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic [7:0] cnt_q, cnt_d;
    logic       start_q;
    logic       field_init_q, field_init_d;
    logic       play_enable_q, play_enable_d;
    logic       game_over_q, game_over_d;

    logic       start_event;
    logic [8:0] cnt_tick;
    logic       pause_done;

    assign start_event = start && !start_q;
    assign cnt_tick    = {1'b0, cnt_q} + 9'd1;
    assign pause_done  = frame_tick && (cnt_tick == PAUSE_LAST);

    // start_q resets high so a button held through reset cannot start a game.
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            lives_q       <= 2'd0;
            level_q       <= 4'd0;
            cnt_q         <= 8'd0;
            start_q       <= 1'b1;
            field_init_q  <= 1'b0;
            play_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            start_q       <= start;
            field_init_q  <= field_init_d;
            play_enable_q <= play_enable_d;
            game_over_q   <= game_over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_event) begin
                    state_d = ST_INIT;
                    lives_d = LIVES_INIT;
                    level_d = 4'd0;
                end
            end
            ST_INIT: state_d = ST_PLAY;
            ST_PLAY: begin
                // Only the highest-priority event is acted on.
                if (invaders_landed) begin
                    state_d = ST_OVER;
                    lives_d = 2'd0;
                end else if (player_hit) begin
                    if (lives_q <= 2'd1) begin
                        state_d = ST_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = ST_HIT_PAUSE;
                        lives_d = lives_q - 2'd1;
                        cnt_d   = 8'd0;
                    end
                end else if (wave_cleared) begin
                    state_d = ST_WAVE_PAUSE;
                    cnt_d   = 8'd0;
                    if (level_q < LEVEL_MAX) begin
                        level_d = level_q + 4'd1;
                    end
                end
            end
            ST_HIT_PAUSE, ST_WAVE_PAUSE: begin
                if (frame_tick) begin
                    cnt_d = cnt_tick[7:0];
                end
                if (pause_done) begin
                    state_d = (state_q == ST_HIT_PAUSE) ? ST_PLAY : ST_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Flag outputs are decoded from the next state so they register alongside it.
    always_comb begin
        field_init_d  = (state_d == ST_INIT);
        play_enable_d = (state_d == ST_PLAY);
        game_over_d   = (state_d == ST_OVER);
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign field_init  = field_init_q;
    assign play_enable = play_enable_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_space_invaders_game_ctrl.sv
// Bench for space_invaders_game_ctrl: directed scenarios plus randomized play,
// checked every cycle against a transaction-level game model.
module tb_space_invaders_game_ctrl;

    localparam int P_LIVES = 3;
    localparam int P_PAUSE = 2;
    localparam int P_MAXLV = 15;

    logic       clk_12MHz = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b1;
    logic       frame_tick = 1'b0;
    logic       player_hit = 1'b0;
    logic       wave_cleared = 1'b0;
    logic       invaders_landed = 1'b0;
    logic [2:0] state;
    logic       field_init;
    logic       play_enable;
    logic [1:0] lives;
    logic [3:0] level;
    logic       game_over;

    int n_cmp = 0;
    int n_fail = 0;
    int fi_count = 0;
    bit check_en = 1'b0;

    space_invaders_game_ctrl #(
        .INIT_LIVES  (P_LIVES),
        .PAUSE_FRAMES(P_PAUSE),
        .MAX_LEVEL   (P_MAXLV)
    ) dut (
        .clk_12MHz      (clk_12MHz),
        .reset          (reset),
        .start          (start),
        .frame_tick     (frame_tick),
        .player_hit     (player_hit),
        .wave_cleared   (wave_cleared),
        .invaders_landed(invaders_landed),
        .state          (state),
        .field_init     (field_init),
        .play_enable    (play_enable),
        .lives          (lives),
        .level          (level),
        .game_over      (game_over)
    );

    always #10 clk_12MHz = ~clk_12MHz;

    // Game model: names rather than encodings, plain integers for counters.
    typedef enum int {G_IDLE, G_INIT, G_PLAY, G_HIT, G_WAVE, G_OVER} phase_t;
    typedef struct {
        phase_t phase;
        int     lives;
        int     level;
        int     frames;
        bit     btn_prev;
    } game_t;

    game_t m;

    function automatic game_t reset_game();
        game_t g;
        g.phase = G_IDLE; g.lives = 0; g.level = 0; g.frames = 0; g.btn_prev = 1'b1;
        return g;
    endfunction

    function automatic int phase_code(phase_t p);
        case (p)
            G_IDLE: return 0;
            G_INIT: return 1;
            G_PLAY: return 2;
            G_HIT:  return 3;
            G_WAVE: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic game_t advance(game_t g, bit st, bit ft, bit ph, bit wc, bit il);
        game_t r = g;
        bit pressed = st && !g.btn_prev;
        r.btn_prev = st;
        if (g.phase == G_IDLE || g.phase == G_OVER) begin
            if (pressed) begin
                r.phase = G_INIT; r.lives = P_LIVES; r.level = 0;
            end
        end else if (g.phase == G_INIT) begin
            r.phase = G_PLAY;
        end else if (g.phase == G_PLAY) begin
            if (il) begin
                r.phase = G_OVER; r.lives = 0;
            end else if (ph) begin
                r.lives = (g.lives > 0) ? g.lives - 1 : 0;
                r.phase = (r.lives == 0) ? G_OVER : G_HIT;
                r.frames = 0;
            end else if (wc) begin
                r.phase = G_WAVE;
                r.level = (g.level + 1 > P_MAXLV) ? P_MAXLV : g.level + 1;
                r.frames = 0;
            end
        end else if (ft) begin
            r.frames = g.frames + 1;
            if (r.frames == P_PAUSE) r.phase = (g.phase == G_HIT) ? G_PLAY : G_INIT;
        end
        return r;
    endfunction

    always @(posedge clk_12MHz or negedge reset) begin
        if (!reset) m <= reset_game();
        else        m <= advance(m, start, frame_tick, player_hit, wave_cleared, invaders_landed);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_12MHz) begin
        if (check_en) begin
            chk("state", int'(state), phase_code(m.phase));
            chk("lives", int'(lives), m.lives);
            chk("level", int'(level), m.level);
            chk("field_init", int'(field_init), int'(m.phase == G_INIT));
            chk("play_enable", int'(play_enable), int'(m.phase == G_PLAY));
            chk("game_over", int'(game_over), int'(m.phase == G_OVER));
            if (field_init) fi_count++;
        end
    end

    // One clock with the given pulses applied; returns 2 time units after the edge.
    task automatic step(input bit ft, input bit ph, input bit wc, input bit il);
        frame_tick = ft; player_hit = ph; wave_cleared = wc; invaders_landed = il;
        @(posedge clk_12MHz);
        #2;
        frame_tick = 1'b0; player_hit = 1'b0; wave_cleared = 1'b0; invaders_landed = 1'b0;
        $display("step ft=%0b ph=%0b wc=%0b il=%0b st=%0b -> state=%0d lives=%0d level=%0d fi=%0b pe=%0b go=%0b",
                 ft, ph, wc, il, start, state, lives, level, field_init, play_enable, game_over);
    endtask

    task automatic press_start();
        start = 1'b0;
        step(0, 0, 0, 0);
        start = 1'b1;
        step(0, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_lives"}, int'(lives), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_fi"}, int'(field_init), 0);
        chk({tag, "_pe"}, int'(play_enable), 0);
        chk({tag, "_go"}, int'(game_over), 0);
    endtask

    initial begin
        m = reset_game();
        #5;
        check_en = 1'b1;
        repeat (3) @(posedge clk_12MHz);
        #2;
        check_reset_values("in_reset");

        // Release with the button held: must stay idle.
        reset = 1'b1;
        repeat (3) step(0, 0, 0, 0);
        chk("held_start_idle", int'(state), 0);

        press_start();
        chk("init_state", int'(state), 1);
        chk("init_pulse", int'(field_init), 1);
        step(0, 0, 0, 0);
        chk("play_state", int'(state), 2);
        chk("play_lives", int'(lives), 3);
        chk("play_level", int'(level), 0);
        chk("play_pe", int'(play_enable), 1);
        chk("init_pulse_width", int'(field_init), 0);

        step(0, 1, 0, 0);
        chk("hit_lives", int'(lives), 2);
        chk("hit_state", int'(state), 3);
        chk("hit_pe", int'(play_enable), 0);
        fi_count = 0;
        step(1, 0, 0, 0);
        chk("pause_mid", int'(state), 3);
        step(1, 0, 0, 0);
        chk("pause_done_play", int'(state), 2);
        step(0, 0, 0, 0);
        chk("no_fi_after_hit", fi_count, 0);

        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("over_lives", int'(lives), 0);
        chk("over_state", int'(state), 5);
        chk("over_go", int'(game_over), 1);
        step(0, 1, 0, 0);
        chk("over_hold", int'(state), 5);
        press_start();
        chk("restart_state", int'(state), 1);
        chk("restart_lives", int'(lives), 3);
        chk("restart_level", int'(level), 0);
        step(0, 0, 0, 0);

        step(0, 1, 1, 0);
        chk("hit_wave_lives", int'(lives), 2);
        chk("hit_wave_level", int'(level), 0);
        chk("hit_wave_state", int'(state), 3);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        chk("landed_state", int'(state), 5);
        chk("landed_lives", int'(lives), 0);

        // Sixteen waves: level saturates, one field_init per wave plus the initial one.
        fi_count = 0;
        press_start();
        step(0, 0, 0, 0);
        for (int w = 0; w < 16; w++) begin
            step(0, 0, 1, 0);
            step(1, 0, 0, 0);
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        chk("wave_level_sat", int'(level), 15);
        chk("wave_fi_count", fi_count, 17);

        // Asynchronous reset in a wave pause with one frame counted.
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("wave_pause_state", int'(state), 4);
        #3 reset = 1'b0;
        #1 check_reset_values("async");
        @(posedge clk_12MHz);
        #2 reset = 1'b1;
        repeat (3) step(0, 1, 0, 0);
        chk("idle_ignores_hit", int'(state), 0);

        // Randomized play with occasional mid-cycle resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) start = ~start;
            if ($urandom_range(599) == 0) begin
                #($urandom_range(6) + 1) reset = 1'b0;
                #1 chk("rand_async_state", int'(state), 0);
                @(posedge clk_12MHz);
                #2 reset = 1'b1;
            end
            step($urandom_range(2) == 0, $urandom_range(11) == 0,
                 $urandom_range(9) == 0, $urandom_range(39) == 0);
        end

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
